// File: rtl/prefetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prefetch_pkg
// Description : Shared types and default thresholds for the prefetch
//               confidence tracker.
// Revision    : 1.0 - initial release
// ============================================================================
package prefetch_pkg;

  // Hysteresis states: not yet warm, warm but gated, warm and issuing
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OFF  = 2'd1,
    ON   = 2'd2
  } pf_conf_state_t;

  localparam int PF_LOG_VEC_SIZE_DEFAULT = 3;
  localparam int PF_ON_THRESH_DEFAULT    = 6;
  localparam int PF_OFF_THRESH_DEFAULT   = 3;

endpackage
`default_nettype wire

// File: rtl/onesCnt.sv
`default_nettype none
// ============================================================================
// Module      : onesCnt
// Description : Combinational popcount of a 2**LOG_VEC_SIZE bit vector. The
//               result is LOG_VEC_SIZE bits wide, so callers keep at least one
//               input bit at zero to stay within range.
// Revision    : 1.0 - initial release
// ============================================================================
module onesCnt #(
  parameter int LOG_VEC_SIZE = 3
) (
  input  logic [(1<<LOG_VEC_SIZE)-1:0] A,
  output logic [LOG_VEC_SIZE-1:0]      ones
);

  localparam int VEC_SIZE = 1 << LOG_VEC_SIZE;

  // Sum every bit of the input vector
  always_comb begin
    ones = '0;
    for (int i = 0; i < VEC_SIZE; i++) begin
      ones = ones + LOG_VEC_SIZE'(A[i]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/pf_confidence_tracker.sv
`default_nettype none
// ============================================================================
// Module      : pf_confidence_tracker
// Description : Sliding hit/miss history for one prefetch stream, popcounted
//               into a confidence value, with a hysteresis FSM that gates
//               prefetch issue.
// Revision    : 1.0 - initial release
// ============================================================================
module pf_confidence_tracker
  import prefetch_pkg::*;
#(
  parameter int LOG_VEC_SIZE = PF_LOG_VEC_SIZE_DEFAULT,
  parameter int ON_THRESH    = PF_ON_THRESH_DEFAULT,
  parameter int OFF_THRESH   = PF_OFF_THRESH_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         access_valid,
  input  logic                         access_hit,
  output logic [(1<<LOG_VEC_SIZE)-1:0] hist,
  output logic [LOG_VEC_SIZE-1:0]      conf,
  output logic                         pf_enable,
  output logic                         warm
);

  localparam int VEC_SIZE = 1 << LOG_VEC_SIZE;

  localparam logic [LOG_VEC_SIZE-1:0] C_FILL_MAX = LOG_VEC_SIZE'(VEC_SIZE - 1);
  localparam logic [LOG_VEC_SIZE-1:0] C_ON_THR   = LOG_VEC_SIZE'(ON_THRESH);
  localparam logic [LOG_VEC_SIZE-1:0] C_OFF_THR  = LOG_VEC_SIZE'(OFF_THRESH);

  // Reject threshold sets that cannot be represented or would never toggle
  if (!(LOG_VEC_SIZE >= 2 && OFF_THRESH >= 0 && OFF_THRESH < ON_THRESH &&
        ON_THRESH <= VEC_SIZE - 1)) begin : g_param_check
    $error("pf_confidence_tracker: need 0 <= OFF_THRESH < ON_THRESH <= VEC_SIZE-1");
  end

  logic [VEC_SIZE-1:0]     hist_q, hist_d;
  logic [LOG_VEC_SIZE-1:0] fill_q, fill_d;
  pf_conf_state_t          state_q, state_d;

  // Next history and fill count; the top history bit stays 0 so the
  // popcount never exceeds VEC_SIZE-1
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (access_valid) begin
      hist_d = {1'b0, hist_q[VEC_SIZE-3:0], access_hit};
      if (fill_q != C_FILL_MAX) begin
        fill_d = fill_q + 1'b1;
      end
    end
  end

  // Hysteresis decision on the registered confidence and warm flag
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (warm) state_d = (conf >= C_ON_THR) ? ON : OFF;
      OFF:  if (conf >= C_ON_THR)  state_d = ON;
      ON:   if (conf <= C_OFF_THR) state_d = OFF;
      default: state_d = IDLE;
    endcase
  end

  // State registers; flush restarts the stream exactly like reset and
  // takes priority over a same-cycle access
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      hist_q  <= '0;
      fill_q  <= '0;
      state_q <= IDLE;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      state_q <= state_d;
    end
  end

  onesCnt #(
    .LOG_VEC_SIZE(LOG_VEC_SIZE)
  ) u_ones_cnt (
    .A   (hist),
    .ones(conf)
  );

  assign hist      = hist_q;
  assign warm      = (fill_q == C_FILL_MAX);
  assign pf_enable = (state_q == ON);

endmodule
`default_nettype wire
